// File: rtl/qtable_wb_buffer.sv
// Write-back buffer between the Q-learning update pipeline and the Q-table RAM.
// Coalesces repeat updates to pending non-head keys and forwards pending Q values to lookups.
module qtable_wb_buffer #(
  parameter int Q_W   = 16,
  parameter int S_W   = 6,
  parameter int A_W   = 4,
  parameter int DEPTH = 4,
  localparam int KW   = S_W + A_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [S_W-1:0] in_state,
  input  logic [A_W-1:0] in_action,
  input  logic [Q_W-1:0] in_q,
  output logic           mem_wr_en,
  output logic [KW-1:0]  mem_wr_addr,
  output logic [Q_W-1:0] mem_wr_data,
  input  logic           mem_ack,
  input  logic           lk_valid,
  input  logic [S_W-1:0] lk_state,
  input  logic [A_W-1:0] lk_action,
  output logic           lk_out_valid,
  output logic           lk_hit,
  output logic [Q_W-1:0] lk_q,
  output logic [CW-1:0]  count
);

  logic [KW-1:0]  key_q [DEPTH];
  logic [KW-1:0]  key_d [DEPTH];
  logic [Q_W-1:0] val_q [DEPTH];
  logic [Q_W-1:0] val_d [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           lk_out_valid_q, lk_out_valid_d;
  logic           lk_hit_q, lk_hit_d;
  logic [Q_W-1:0] lk_q_q, lk_q_d;

  logic [KW-1:0]  in_key, lk_key;
  logic           accept, pop, match_hit;
  logic [PW-1:0]  match_idx;

  assign in_key      = {in_state, in_action};
  assign lk_key      = {lk_valid ? lk_state : lk_state, lk_action};
  assign in_ready    = !rst && (count_q < CW'(DEPTH));
  assign mem_wr_en   = (count_q != '0);
  assign mem_wr_addr = key_q[head_q];
  assign mem_wr_data = val_q[head_q];
  assign count       = count_q;
  assign lk_out_valid = lk_out_valid_q;
  assign lk_hit      = lk_hit_q;
  assign lk_q        = lk_q_q;

  always_comb begin
    key_d          = key_q;
    val_d          = val_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    match_hit      = 1'b0;
    match_idx      = '0;
    lk_out_valid_d = lk_valid;
    lk_hit_d       = 1'b0;
    lk_q_d         = '0;

    accept = in_valid && in_ready;
    pop    = mem_ack && (count_q != '0);

    // Only non-head entries may coalesce; the head is already in flight to the RAM.
    for (int i = 1; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (key_q[head_q + PW'(i)] == in_key)) begin
        match_hit = 1'b1;
        match_idx = head_q + PW'(i);
      end
    end

    if (accept) begin
      if (match_hit) begin
        val_d[match_idx] = in_q;
      end else begin
        key_d[tail_q] = in_key;
        val_d[tail_q] = in_q;
        tail_d        = tail_q + PW'(1);
      end
    end

    if (pop) begin
      head_d = head_q + PW'(1);
    end

    case ({accept && !match_hit, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Lookup sees the post-edge queue; a non-head match outranks the head.
    if (lk_valid) begin
      if ((count_d != '0) && (key_d[head_d] == lk_key)) begin
        lk_hit_d = 1'b1;
        lk_q_d   = val_d[head_d];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if ((CW'(i) < count_d) && (key_d[head_d + PW'(i)] == lk_key)) begin
          lk_hit_d = 1'b1;
          lk_q_d   = val_d[head_d + PW'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      lk_out_valid_q <= 1'b0;
      lk_hit_q       <= 1'b0;
      lk_q_q         <= '0;
    end else begin
      key_q          <= key_d;
      val_q          <= val_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      lk_out_valid_q <= lk_out_valid_d;
      lk_hit_q       <= lk_hit_d;
      lk_q_q         <= lk_q_d;
    end
  end

endmodule

// File: tb/tb_qtable_wb_buffer.sv
// Directed bench for qtable_wb_buffer: a vector table for single-cycle behaviour,
// plus hand-written wrap and mid-stream reset sequences.
module tb_qtable_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_state;
  logic [3:0]  in_action;
  logic [15:0] in_q;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_ack;
  logic        lk_valid;
  logic [5:0]  lk_state;
  logic [3:0]  lk_action;
  logic        lk_out_valid;
  logic        lk_hit;
  logic [15:0] lk_q;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qtable_wb_buffer #(.Q_W(16), .S_W(6), .A_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_action(in_action), .in_q(in_q),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_ack(mem_ack),
    .lk_valid(lk_valid), .lk_state(lk_state), .lk_action(lk_action),
    .lk_out_valid(lk_out_valid), .lk_hit(lk_hit), .lk_q(lk_q),
    .count(count)
  );

  typedef struct {
    string       name;
    bit          iv;
    bit [5:0]    s;
    bit [3:0]    a;
    bit [15:0]   q;
    bit          ack;
    bit          lv;
    bit [5:0]    ls;
    bit [3:0]    la;
    bit [2:0]    e_cnt;
    bit          e_wen;
    bit [9:0]    e_addr;
    bit [15:0]   e_data;
    bit          e_rdy;
    bit          e_lov;
    bit          e_hit;
    bit [15:0]   e_lq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, bit iv, bit [5:0] s, bit [3:0] a, bit [15:0] q,
                              bit ack, bit lv, bit [5:0] ls, bit [3:0] la,
                              bit [2:0] e_cnt, bit e_wen, bit [9:0] e_addr, bit [15:0] e_data,
                              bit e_rdy, bit e_lov, bit e_hit, bit [15:0] e_lq);
    vec_t v;
    v.name = name; v.iv = iv; v.s = s; v.a = a; v.q = q; v.ack = ack;
    v.lv = lv; v.ls = ls; v.la = la;
    v.e_cnt = e_cnt; v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rdy = e_rdy; v.e_lov = e_lov; v.e_hit = e_hit; v.e_lq = e_lq;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit iv, bit [5:0] s, bit [3:0] a, bit [15:0] q,
                       bit ack, bit lv, bit [5:0] ls, bit [3:0] la);
    @(negedge clk);
    in_valid = iv; in_state = s; in_action = a; in_q = q;
    mem_ack = ack; lk_valid = lv; lk_state = ls; lk_action = la;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_state = 0; in_action = 0; in_q = 0;
    mem_ack = 0; lk_valid = 0; lk_state = 0; lk_action = 0;

    // name                 iv s  a  q        ack lv ls la   cnt wen addr    data     rdy lov hit lq
    add("single_push",      1, 5, 2, 16'h0123, 0, 0, 0, 0,   1, 1, 10'h052, 16'h0123, 1, 0, 0, 16'h0);
    add("single_hold",      0, 0, 0, 16'h0,    0, 0, 0, 0,   1, 1, 10'h052, 16'h0123, 1, 0, 0, 16'h0);
    add("single_ack",       0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("full_p0",          1, 1, 0, 16'h1000, 0, 0, 0, 0,   1, 1, 10'h010, 16'h1000, 1, 0, 0, 16'h0);
    add("full_p1",          1, 1, 1, 16'h1001, 0, 0, 0, 0,   2, 1, 10'h010, 16'h1000, 1, 0, 0, 16'h0);
    add("full_p2",          1, 1, 2, 16'h1002, 0, 0, 0, 0,   3, 1, 10'h010, 16'h1000, 1, 0, 0, 16'h0);
    add("full_p3",          1, 1, 3, 16'h1003, 0, 0, 0, 0,   4, 1, 10'h010, 16'h1000, 0, 0, 0, 16'h0);
    add("full_reject",      1, 2, 0, 16'h2000, 0, 0, 0, 0,   4, 1, 10'h010, 16'h1000, 0, 0, 0, 16'h0);
    add("full_pop_noaccept",1, 2, 0, 16'h2000, 1, 0, 0, 0,   3, 1, 10'h011, 16'h1001, 1, 0, 0, 16'h0);
    add("full_drain1",      0, 0, 0, 16'h0,    1, 0, 0, 0,   2, 1, 10'h012, 16'h1002, 1, 0, 0, 16'h0);
    add("full_drain2",      0, 0, 0, 16'h0,    1, 0, 0, 0,   1, 1, 10'h013, 16'h1003, 1, 0, 0, 16'h0);
    add("full_drain3",      0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("empty_ack_ignored",0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("coal_p0",          1, 1, 1, 16'h0010, 0, 0, 0, 0,   1, 1, 10'h011, 16'h0010, 1, 0, 0, 16'h0);
    add("coal_p1",          1, 2, 0, 16'h0020, 0, 0, 0, 0,   2, 1, 10'h011, 16'h0010, 1, 0, 0, 16'h0);
    add("coal_merge",       1, 2, 0, 16'h0030, 0, 0, 0, 0,   2, 1, 10'h011, 16'h0010, 1, 0, 0, 16'h0);
    add("coal_lookup",      0, 0, 0, 16'h0,    0, 1, 2, 0,   2, 1, 10'h011, 16'h0010, 1, 1, 1, 16'h0030);
    add("coal_drain1",      0, 0, 0, 16'h0,    1, 0, 0, 0,   1, 1, 10'h020, 16'h0030, 1, 0, 0, 16'h0);
    add("coal_drain2",      0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("head_p0",          1, 3, 3, 16'hAAAA, 0, 0, 0, 0,   1, 1, 10'h033, 16'hAAAA, 1, 0, 0, 16'h0);
    add("head_p1_lk_same",  1, 3, 3, 16'hBBBB, 0, 1, 3, 3,   2, 1, 10'h033, 16'hAAAA, 1, 1, 1, 16'hBBBB);
    add("head_lookup",      0, 0, 0, 16'h0,    0, 1, 3, 3,   2, 1, 10'h033, 16'hAAAA, 1, 1, 1, 16'hBBBB);
    add("head_lookup_miss", 0, 0, 0, 16'h0,    0, 1, 4, 4,   2, 1, 10'h033, 16'hAAAA, 1, 1, 0, 16'h0);
    add("head_drain1",      0, 0, 0, 16'h0,    1, 0, 0, 0,   1, 1, 10'h033, 16'hBBBB, 1, 0, 0, 16'h0);
    add("head_lk_only",     0, 0, 0, 16'h0,    0, 1, 3, 3,   1, 1, 10'h033, 16'hBBBB, 1, 1, 1, 16'hBBBB);
    add("head_drain2",      0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("pop_lk_push",      1, 7, 1, 16'h7FFF, 0, 0, 0, 0,   1, 1, 10'h071, 16'h7FFF, 1, 0, 0, 16'h0);
    add("pop_lk_same_edge", 0, 0, 0, 16'h0,    1, 1, 7, 1,   0, 0, 10'h0,   16'h0,    1, 1, 0, 16'h0);
    add("pop_lk_pulse_end", 0, 0, 0, 16'h0,    0, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("cpop_p0",          1, 1, 0, 16'h0100, 0, 0, 0, 0,   1, 1, 10'h010, 16'h0100, 1, 0, 0, 16'h0);
    add("cpop_p1",          1, 2, 0, 16'h0200, 0, 0, 0, 0,   2, 1, 10'h010, 16'h0100, 1, 0, 0, 16'h0);
    add("cpop_merge_pop",   1, 2, 0, 16'h0222, 1, 0, 0, 0,   1, 1, 10'h020, 16'h0222, 1, 0, 0, 16'h0);
    add("cpop_drain",       0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);
    add("pp_p0",            1, 4, 0, 16'h4000, 0, 0, 0, 0,   1, 1, 10'h040, 16'h4000, 1, 0, 0, 16'h0);
    add("pp_push_pop",      1, 4, 1, 16'h4001, 1, 0, 0, 0,   1, 1, 10'h041, 16'h4001, 1, 0, 0, 16'h0);
    add("pp_drain",         0, 0, 0, 16'h0,    1, 0, 0, 0,   0, 0, 10'h0,   16'h0,    1, 0, 0, 16'h0);

    // Outputs while reset is held.
    #1;
    check("rst_count", count, 0);
    check("rst_wen", mem_wr_en, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_lov", lk_out_valid, 0);
    check("rst_hit", lk_hit, 0);
    check("rst_lq", lk_q, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].s, vecs[i].a, vecs[i].q,
            vecs[i].ack, vecs[i].lv, vecs[i].ls, vecs[i].la);
      check({vecs[i].name, "_count"}, count, vecs[i].e_cnt);
      check({vecs[i].name, "_wen"}, mem_wr_en, vecs[i].e_wen);
      if (vecs[i].e_wen) begin
        check({vecs[i].name, "_addr"}, mem_wr_addr, vecs[i].e_addr);
        check({vecs[i].name, "_data"}, mem_wr_data, vecs[i].e_data);
      end
      check({vecs[i].name, "_in_ready"}, in_ready, vecs[i].e_rdy);
      check({vecs[i].name, "_lov"}, lk_out_valid, vecs[i].e_lov);
      check({vecs[i].name, "_hit"}, lk_hit, vecs[i].e_hit);
      check({vecs[i].name, "_lq"}, lk_q, vecs[i].e_lq);
    end

    // Wrap: each push overlaps the ack of the previous entry, walking pointers past DEPTH.
    drive(1, 6'd8, 4'd5, 16'h0500, 0, 0, 0, 0);
    check("wrap_first_addr", mem_wr_addr, {6'd8, 4'd5});
    check("wrap_first_data", mem_wr_data, 16'h0500);
    for (int i = 1; i < 10; i++) begin
      drive(1, 6'(8 + i), 4'd5, 16'h0500 + 16'(i), 1, 0, 0, 0);
      check($sformatf("wrap_%0d_count", i), count, 1);
      check($sformatf("wrap_%0d_addr", i), mem_wr_addr, {6'(8 + i), 4'd5});
      check($sformatf("wrap_%0d_data", i), mem_wr_data, 16'h0500 + 16'(i));
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    check("wrap_end_count", count, 0);

    // Mid-stream reset with three pending entries.
    drive(1, 6'd9, 4'd1, 16'h0901, 0, 0, 0, 0);
    drive(1, 6'd9, 4'd2, 16'h0902, 0, 0, 0, 0);
    drive(1, 6'd9, 4'd3, 16'h0903, 0, 1, 6'd9, 4'd3);
    check("mid_count_pre", count, 3);
    check("mid_lk_hit_pre", lk_hit, 1);
    @(negedge clk);
    in_valid = 0; lk_valid = 0; mem_ack = 0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_wen", mem_wr_en, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_lov", lk_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 6'd9, 4'd2);
    check("mid_post_lov", lk_out_valid, 1);
    check("mid_post_hit", lk_hit, 0);
    check("mid_post_lq", lk_q, 0);
    check("mid_post_count", count, 0);
    check("mid_post_in_ready", in_ready, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qtable_wb_buffer.md
Name: qtable_wb_buffer

Overview:
- Write-back buffer at the tail of the Q-learning update pipeline.
- Consumes pipeline-aligned (state, action, new Q) update requests and queues them.
- Drains them to the Q-table RAM write port through a valid/ack handshake.
- Serves a registered lookup port so the pipeline front end reads pending, not-yet-committed Q values (read-after-write forwarding).

Parameters:
- Q_W, 16, Q-value width (two's complement, carried opaquely)
- S_W, 6, state index width
- A_W, 4, action index width
- DEPTH, 4, pending-entry capacity (power of two, >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  update request present
- in_ready  output  1  buffer can accept a new entry
- in_state  input  S_W  state of update
- in_action  input  A_W  action of update
- in_q  input  Q_W  new Q value
- mem_wr_en  output  1  head entry presented to RAM
- mem_wr_addr  output  S_W+A_W  {state, action} of head
- mem_wr_data  output  Q_W  Q value of head
- mem_ack  input  1  RAM accepted head write this cycle
- lk_valid  input  1  lookup request
- lk_state  input  S_W  lookup state
- lk_action  input  A_W  lookup action
- lk_out_valid  output  1  lookup result valid (one cycle after lk_valid)
- lk_hit  output  1  lookup matched a pending entry
- lk_q  output  Q_W  forwarded Q value (0 when no hit)
- count  output  clog2(DEPTH)+1  pending entries

Behaviour:
- Address key = {state, action}. Circular queue: head pointer, tail pointer, count.
- Reset (async, while rst=1): count=0, pointers=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, lk_out_valid=0, lk_hit=0, lk_q=0, in_ready=0. After rst deasserts, in_ready=1.
- in_ready = (count < DEPTH). Combinational from count only; it does not depend on same-cycle mem_ack. When full, an input is not accepted even if a pop occurs in the same cycle.
- Accept occurs when in_valid && in_ready at the rising edge.
- Coalescing: if the accepted key equals a valid non-head entry, overwrite that entry's Q in place; count is unchanged. Non-head keys are unique by construction, so at most one match.
- A key matching only the head is pushed as a new tail entry. The head is in flight and is never modified.
- When no match exists, push at tail; count+1.
- Drain: mem_wr_en = (count != 0). mem_wr_addr/mem_wr_data show the head entry and stay stable while mem_wr_en=1 until mem_ack. mem_ack when mem_wr_en=0 is ignored.
- On mem_ack && mem_wr_en: pop head; count-1.
- Simultaneous push and pop: count unchanged; pointers advance independently.
- Simultaneous coalesce and pop: count-1.
- A coalesce into the entry that becomes head at that same edge is allowed, because it was non-head when evaluated.
- Pointer wrap: modulo DEPTH.
- Lookup: lk_valid sampled at edge t.
  - At t+1, lk_out_valid=1 for exactly one cycle per request; back-to-back requests are allowed.
  - The search uses queue contents after edge t: includes a same-edge push/coalesce, excludes a same-edge popped head.
  - Result is the youngest matching entry (a non-head match has priority over the head). lk_hit=1 and lk_q = entry Q.
  - No match: lk_hit=0, lk_q=0.
- Reset mid-operation discards all pending entries. No partial RAM write is implied, because the RAM only commits on the mem_ack edge.

Test Plan:
- Reset then single push (s=5, a=2, q=0x0123), mem_ack held 0: mem_wr_en=1, mem_wr_addr=0x052, mem_wr_data=0x0123 stable; count=1. Assert mem_ack one cycle: count=0, mem_wr_en=0.
- Four distinct pushes with mem_ack=0: count=4, in_ready=0. A fifth in_valid is not accepted. Pulse mem_ack with in_valid also high: pop happens, no push, count=3, in_ready=1 next cycle.
- Coalesce: push (1,1,0x0010), (2,0,0x0020), (2,0,0x0030), mem_ack=0. Result: count=2, head still 0x0010. Drain order writes 0x0010 then 0x0030 to addr 0x020.
- Head conflict: push (3,3,0xAAAA), then (3,3,0xBBBB) while the head is pending. Result: count=2. A lookup of (3,3) returns lk_hit=1, lk_q=0xBBBB one cycle later.
- Same-edge lookup/pop: the single entry (7,1,0x7FFF) is acked on the same edge lk_valid is sampled for (7,1). Next cycle lk_out_valid=1, lk_hit=0, lk_q=0.
- Wrap and reset: run 10 push/ack pairs through DEPTH=4 and confirm FIFO order across wrap. Assert rst mid-stream with count=3: count=0, mem_wr_en=0 immediately; lookups miss after release.
